// File: rtl/commit_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : commit_unit_pkg
// Brief   : Shared widths, instruction IDs and commit classification helpers.
// Revision: 1.0
// ============================================================================
package commit_unit_pkg;

    localparam int C_INSTR_ID_WIDTH = 6;
    localparam int C_REG_IDX_WIDTH  = 5;
    localparam int C_ROB_IDX_WIDTH  = 4;
    localparam int C_LSB_IDX_WIDTH  = 4;
    localparam int C_WORD_WIDTH     = 32;
    localparam int C_ADDR_WIDTH     = 32;

    typedef enum logic [C_INSTR_ID_WIDTH-1:0] {
        ID_NOP   = 6'd0,
        ID_LUI, ID_AUIPC, ID_JAL, ID_JALR,
        ID_BEQ, ID_BNE, ID_BLT, ID_BGE, ID_BLTU, ID_BGEU,
        ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU,
        ID_SB, ID_SH, ID_SW,
        ID_ADDI, ID_SLTI, ID_SLTIU, ID_XORI, ID_ORI, ID_ANDI,
        ID_SLLI, ID_SRLI, ID_SRAI,
        ID_ADD, ID_SUB, ID_SLL, ID_SLT, ID_SLTU, ID_XOR,
        ID_SRL, ID_SRA, ID_OR, ID_AND
    } instr_id_e;

    function automatic logic is_store(input logic [C_INSTR_ID_WIDTH-1:0] id);
        return (id == ID_SB) || (id == ID_SH) || (id == ID_SW);
    endfunction

    function automatic logic is_branch(input logic [C_INSTR_ID_WIDTH-1:0] id);
        return (id >= ID_BEQ) && (id <= ID_BGEU);
    endfunction

    function automatic logic writes_rd(input logic [C_INSTR_ID_WIDTH-1:0] id);
        return !is_store(id) && !is_branch(id);
    endfunction

endpackage
`default_nettype wire

// File: rtl/commit_flush_fsm.sv
`default_nettype none
// ============================================================================
// Module  : commit_flush_fsm
// Brief   : RUN/FLUSH/HOLD sequencer that blocks commits after a redirect.
// Revision: 1.0
// ============================================================================
module commit_flush_fsm
    import commit_unit_pkg::*;
#(
    parameter int FLUSH_HOLD = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic flush_start_in,
    output logic busy_out
);

    localparam logic [1:0] C_ST_RUN   = 2'd0;
    localparam logic [1:0] C_ST_FLUSH = 2'd1;
    localparam logic [1:0] C_ST_HOLD  = 2'd2;
    localparam logic [2:0] C_HOLD_LAST = 3'(FLUSH_HOLD - 1);

    logic [1:0] r_state;
    logic [2:0] r_hold_cnt;
    logic [1:0] w_state_nxt;
    logic [2:0] w_hold_cnt_nxt;

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        case (r_state)
            C_ST_RUN: begin
                if (flush_start_in) w_state_nxt = C_ST_FLUSH;
            end
            C_ST_FLUSH: begin
                w_state_nxt    = C_ST_HOLD;
                w_hold_cnt_nxt = 3'd0;
            end
            C_ST_HOLD: begin
                if (r_hold_cnt == C_HOLD_LAST) begin
                    w_state_nxt    = C_ST_RUN;
                    w_hold_cnt_nxt = 3'd0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 3'd1;
                end
            end
            default: begin
                w_state_nxt    = C_ST_RUN;
                w_hold_cnt_nxt = 3'd0;
            end
        endcase
    end

    // busy is registered from the next state so it tracks r_state exactly
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= C_ST_RUN;
            r_hold_cnt <= 3'd0;
            busy_out   <= 1'b0;
        end else if (rdy_in) begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            busy_out   <= (w_state_nxt != C_ST_RUN);
        end
    end

endmodule
`default_nettype wire

// File: rtl/commit_unit.sv
`default_nettype none
// ============================================================================
// Module  : commit_unit
// Brief   : Retires one ROB entry per cycle: RF write, store release, redirect.
// Revision: 1.0
// ============================================================================
module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int FLUSH_HOLD = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        commit_en_in,
    input  logic [C_INSTR_ID_WIDTH-1:0] instr_id_in,
    input  logic [C_REG_IDX_WIDTH-1:0]  rd_in,
    input  logic [C_ROB_IDX_WIDTH-1:0]  rob_pos_in,
    input  logic [C_LSB_IDX_WIDTH-1:0]  lsb_pos_in,
    input  logic [C_WORD_WIDTH-1:0]     res_in,
    input  logic                        jump_en_in,
    input  logic [C_ADDR_WIDTH-1:0]     jump_a_in,
    output logic                        rf_we_out,
    output logic [C_REG_IDX_WIDTH-1:0]  rf_rd_out,
    output logic [C_WORD_WIDTH-1:0]     rf_data_out,
    output logic [C_ROB_IDX_WIDTH-1:0]  rf_rob_pos_out,
    output logic                        lsb_commit_en_out,
    output logic [C_LSB_IDX_WIDTH-1:0]  lsb_commit_pos_out,
    output logic                        clear_branch_out,
    output logic                        pc_redirect_en_out,
    output logic [C_ADDR_WIDTH-1:0]     pc_redirect_a_out,
    output logic                        busy_out,
    output logic [31:0]                 retired_cnt_out,
    output logic [15:0]                 flush_cnt_out
);

    logic w_accept;
    logic w_flush_start;

    assign w_accept      = commit_en_in && rdy_in && !busy_out;
    assign w_flush_start = w_accept && jump_en_in;

    commit_flush_fsm #(
        .FLUSH_HOLD (FLUSH_HOLD)
    ) u_flush_fsm (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .flush_start_in (w_flush_start),
        .busy_out       (busy_out)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rf_we_out          <= 1'b0;
            rf_rd_out          <= '0;
            rf_data_out        <= '0;
            rf_rob_pos_out     <= '0;
            lsb_commit_en_out  <= 1'b0;
            lsb_commit_pos_out <= '0;
            clear_branch_out   <= 1'b0;
            pc_redirect_en_out <= 1'b0;
            pc_redirect_a_out  <= '0;
            retired_cnt_out    <= '0;
            flush_cnt_out      <= '0;
        end else if (rdy_in) begin
            rf_we_out          <= 1'b0;
            lsb_commit_en_out  <= 1'b0;
            clear_branch_out   <= 1'b0;
            pc_redirect_en_out <= 1'b0;
            if (w_accept) begin
                retired_cnt_out <= retired_cnt_out + 32'd1;
                // x0 writes are dropped but the data fields keep their last value
                if (writes_rd(instr_id_in) && (rd_in != '0)) begin
                    rf_we_out      <= 1'b1;
                    rf_rd_out      <= rd_in;
                    rf_data_out    <= res_in;
                    rf_rob_pos_out <= rob_pos_in;
                end
                if (is_store(instr_id_in)) begin
                    lsb_commit_en_out  <= 1'b1;
                    lsb_commit_pos_out <= lsb_pos_in;
                end
                if (jump_en_in) begin
                    clear_branch_out   <= 1'b1;
                    pc_redirect_en_out <= 1'b1;
                    pc_redirect_a_out  <= jump_a_in;
                    flush_cnt_out      <= flush_cnt_out + 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_commit_unit
// Brief   : Directed vector bench for commit_unit with FLUSH_HOLD = 2.
// Revision: 1.0
// ============================================================================
module tb_commit_unit;
    import commit_unit_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        commit_en_in;
    logic [5:0]  instr_id_in;
    logic [4:0]  rd_in;
    logic [3:0]  rob_pos_in;
    logic [3:0]  lsb_pos_in;
    logic [31:0] res_in;
    logic        jump_en_in;
    logic [31:0] jump_a_in;
    logic        rf_we_out;
    logic [4:0]  rf_rd_out;
    logic [31:0] rf_data_out;
    logic [3:0]  rf_rob_pos_out;
    logic        lsb_commit_en_out;
    logic [3:0]  lsb_commit_pos_out;
    logic        clear_branch_out;
    logic        pc_redirect_en_out;
    logic [31:0] pc_redirect_a_out;
    logic        busy_out;
    logic [31:0] retired_cnt_out;
    logic [15:0] flush_cnt_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    commit_unit #(.FLUSH_HOLD(2)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .commit_en_in       (commit_en_in),
        .instr_id_in        (instr_id_in),
        .rd_in              (rd_in),
        .rob_pos_in         (rob_pos_in),
        .lsb_pos_in         (lsb_pos_in),
        .res_in             (res_in),
        .jump_en_in         (jump_en_in),
        .jump_a_in          (jump_a_in),
        .rf_we_out          (rf_we_out),
        .rf_rd_out          (rf_rd_out),
        .rf_data_out        (rf_data_out),
        .rf_rob_pos_out     (rf_rob_pos_out),
        .lsb_commit_en_out  (lsb_commit_en_out),
        .lsb_commit_pos_out (lsb_commit_pos_out),
        .clear_branch_out   (clear_branch_out),
        .pc_redirect_en_out (pc_redirect_en_out),
        .pc_redirect_a_out  (pc_redirect_a_out),
        .busy_out           (busy_out),
        .retired_cnt_out    (retired_cnt_out),
        .flush_cnt_out      (flush_cnt_out)
    );

    typedef struct {
        logic ce; logic rdy; logic [5:0] id; logic [4:0] rd; logic [3:0] rob;
        logic [3:0] lsb; logic [31:0] res; logic jen; logic [31:0] ja;
        logic e_we; logic [4:0] e_rd; logic [31:0] e_data; logic [3:0] e_rob;
        logic e_lsb_en; logic [3:0] e_lsb_pos; logic e_clr; logic [31:0] e_ra;
        logic e_busy; logic [31:0] e_ret; logic [15:0] e_fl;
    } vec_t;

    function automatic vec_t mk(
        logic ce, logic rdy, logic [5:0] id, logic [4:0] rd, logic [3:0] rob,
        logic [3:0] lsb, logic [31:0] res, logic jen, logic [31:0] ja,
        logic e_we, logic [4:0] e_rd, logic [31:0] e_data, logic [3:0] e_rob,
        logic e_lsb_en, logic [3:0] e_lsb_pos, logic e_clr, logic [31:0] e_ra,
        logic e_busy, logic [31:0] e_ret, logic [15:0] e_fl);
        vec_t v;
        v.ce = ce; v.rdy = rdy; v.id = id; v.rd = rd; v.rob = rob; v.lsb = lsb;
        v.res = res; v.jen = jen; v.ja = ja; v.e_we = e_we; v.e_rd = e_rd;
        v.e_data = e_data; v.e_rob = e_rob; v.e_lsb_en = e_lsb_en;
        v.e_lsb_pos = e_lsb_pos; v.e_clr = e_clr; v.e_ra = e_ra;
        v.e_busy = e_busy; v.e_ret = e_ret; v.e_fl = e_fl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        commit_en_in = v.ce;  rdy_in = v.rdy; instr_id_in = v.id; rd_in = v.rd;
        rob_pos_in   = v.rob; lsb_pos_in = v.lsb; res_in = v.res;
        jump_en_in   = v.jen; jump_a_in = v.ja;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, " rf_we"},     {31'd0, rf_we_out},          {31'd0, v.e_we});
        chk({tag, " rf_rd"},     {27'd0, rf_rd_out},          {27'd0, v.e_rd});
        chk({tag, " rf_data"},   rf_data_out,                 v.e_data);
        chk({tag, " rf_rob"},    {28'd0, rf_rob_pos_out},     {28'd0, v.e_rob});
        chk({tag, " lsb_en"},    {31'd0, lsb_commit_en_out},  {31'd0, v.e_lsb_en});
        chk({tag, " lsb_pos"},   {28'd0, lsb_commit_pos_out}, {28'd0, v.e_lsb_pos});
        chk({tag, " clear"},     {31'd0, clear_branch_out},   {31'd0, v.e_clr});
        chk({tag, " redir_en"},  {31'd0, pc_redirect_en_out}, {31'd0, v.e_clr});
        chk({tag, " redir_a"},   pc_redirect_a_out,           v.e_ra);
        chk({tag, " busy"},      {31'd0, busy_out},           {31'd0, v.e_busy});
        chk({tag, " retired"},   retired_cnt_out,             v.e_ret);
        chk({tag, " flush_cnt"}, {16'd0, flush_cnt_out},      {16'd0, v.e_fl});
    endtask

    vec_t tbl [20];
    vec_t zero_v;

    initial begin
        zero_v = mk(0,1,ID_NOP,0,0,0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0,0);
        //           inputs: ce rdy id rd rob lsb res jen ja | expected outputs
        tbl[0]  = mk(1,1,ID_ADDI,5,2,0,32'h2A,0,0,        1,5,32'h2A,2,   0,0, 0,0,       0,1,0);
        tbl[1]  = mk(1,1,ID_ADD,0,3,0,32'h55,0,0,         0,5,32'h2A,2,   0,0, 0,0,       0,2,0);
        tbl[2]  = mk(1,1,ID_SW,7,4,3,32'h99,0,0,          0,5,32'h2A,2,   1,3, 0,0,       0,3,0);
        tbl[3]  = mk(0,1,ID_ADDI,8,5,0,32'h11,0,0,        0,5,32'h2A,2,   0,3, 0,0,       0,3,0);
        tbl[4]  = mk(1,1,ID_BEQ,9,6,1,32'h1,1,32'h1000,   0,5,32'h2A,2,   0,3, 1,32'h1000,1,4,1);
        tbl[5]  = mk(1,1,ID_BEQ,0,0,0,0,1,32'h2000,       0,5,32'h2A,2,   0,3, 0,32'h1000,1,4,1);
        tbl[6]  = mk(1,1,ID_ADDI,10,7,0,32'hAA,0,0,       0,5,32'h2A,2,   0,3, 0,32'h1000,1,4,1);
        tbl[7]  = mk(1,1,ID_SW,0,0,9,0,0,0,               0,5,32'h2A,2,   0,3, 0,32'h1000,0,4,1);
        tbl[8]  = mk(1,1,ID_ADDI,6,8,0,32'h77,0,0,        1,6,32'h77,8,   0,3, 0,32'h1000,0,5,1);
        tbl[9]  = mk(1,1,ID_JAL,1,9,0,32'h104,1,32'h300,  1,1,32'h104,9,  0,3, 1,32'h300, 1,6,2);
        tbl[10] = mk(0,1,ID_NOP,0,0,0,0,0,0,              0,1,32'h104,9,  0,3, 0,32'h300, 1,6,2);
        tbl[11] = mk(0,1,ID_NOP,0,0,0,0,0,0,              0,1,32'h104,9,  0,3, 0,32'h300, 1,6,2);
        tbl[12] = mk(0,1,ID_NOP,0,0,0,0,0,0,              0,1,32'h104,9,  0,3, 0,32'h300, 0,6,2);
        tbl[13] = mk(1,1,ID_ADDI,2,10,0,32'h9,0,0,        1,2,32'h9,10,   0,3, 0,32'h300, 0,7,2);
        tbl[14] = mk(1,0,ID_ADDI,3,11,0,32'h5,0,0,        1,2,32'h9,10,   0,3, 0,32'h300, 0,7,2);
        tbl[15] = mk(0,1,ID_NOP,0,0,0,0,0,0,              0,2,32'h9,10,   0,3, 0,32'h300, 0,7,2);
        tbl[16] = mk(1,1,ID_BNE,4,12,5,32'hF,0,0,         0,2,32'h9,10,   0,3, 0,32'h300, 0,8,2);
        tbl[17] = mk(1,1,ID_SH,4,13,6,0,0,0,              0,2,32'h9,10,   1,6, 0,32'h300, 0,9,2);
        tbl[18] = mk(0,0,ID_NOP,0,0,0,0,0,0,              0,2,32'h9,10,   1,6, 0,32'h300, 0,9,2);
        tbl[19] = mk(0,1,ID_NOP,0,0,0,0,0,0,              0,2,32'h9,10,   0,6, 0,32'h300, 0,9,2);

        rst_in = 1'b0;
        drive(zero_v);
        repeat (2) @(posedge clk_in);
        #1;
        check_all("reset", zero_v);
        @(negedge clk_in);
        rst_in = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i]);
            @(posedge clk_in);
            #1;
            check_all($sformatf("row%0d", i), tbl[i]);
        end

        // Reset asserted while the flush sequencer is in HOLD
        drive(mk(1,1,ID_BEQ,0,1,0,0,1,32'h40, 0,0,0,0, 0,0, 0,0, 0,0,0));
        @(posedge clk_in);
        #1;
        chk("hold clear", {31'd0, clear_branch_out}, 32'd1);
        drive(zero_v);
        @(posedge clk_in);
        #1;
        chk("hold busy", {31'd0, busy_out}, 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        check_all("async_rst", zero_v);
        @(negedge clk_in);
        rst_in = 1'b1;
        drive(mk(1,1,ID_ADDI,4,3,0,32'h5A5A,0,0, 0,0,0,0, 0,0, 0,0, 0,0,0));
        @(posedge clk_in);
        #1;
        check_all("post_rst", mk(0,1,ID_NOP,0,0,0,0,0,0, 1,4,32'h5A5A,3, 0,0, 0,0, 0,1,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
